pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Sequences the Gowin PLLVR on the 27 MHz reference clock. It drives the PLL RESET pin and
//  watches LOCK (asynchronous to clk). It holds the downstream system reset until LOCK has been
//  stable for a programmable time. On lock loss, lock timeout or a software request it resets
//  and relocks the PLL. Sits between the PLLVR instance and the HyperRAM/system reset tree.
// PARAMETERS
//  RST_CYCLES     16     clk cycles pll_rst is held high per PLL reset pulse (>=1)
//  LOCK_TIMEOUT   27000  clk cycles to wait for lock before re-resetting PLL (~1 ms) (>=2)
//  STABLE_CYCLES  256    consecutive synced-lock cycles required before release (>=1)
//  CNT_W          16     internal counter width; must hold max(all three params)
// PORTS
//  clk          in   1      reference clock (PLL clkin, 27 MHz)
//  rst          in   1      synchronous, active-high reset
//  pll_lock     in   1      PLLVR LOCK, asynchronous; 2-flop synchronized internally
//  relock_req   in   1      1-cycle pulse: force PLL reset/relock (e.g. after divider change)
//  pll_rst      out  1      to PLLVR RESET; high = PLL held in reset
//  sys_rst      out  1      downstream reset, high until PLL is locked and stable
//  pll_ready    out  1      high only in RUN
//  state_o      out  2      current FSM state (debug)
// BEHAVIOUR
//  - Reset (rst=1): state=RESET_PLL, counter=0, sync flops=0, pll_rst=1, sys_rst=1,
//    pll_ready=0, state_o=2'd0. All outputs are registered.
//  - lock_s = pll_lock after 2 flops. A pll_lock edge reaches lock_s 2 cycles later.
//  - States (state_o encoding): RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3.
//  - RESET_PLL: pll_rst=1, sys_rst=1. cnt counts 0..RST_CYCLES-1, then go to WAIT_LOCK with cnt=0.
//    pll_rst is high for exactly RST_CYCLES cycles per entry. lock_s is ignored here.
//  - WAIT_LOCK: pll_rst=0, sys_rst=1.
//    - lock_s=1: go to STABLE, cnt=0.
//    - Otherwise, if cnt==LOCK_TIMEOUT-1: go to RESET_PLL (timeout).
//    - Otherwise cnt++.
//  - STABLE: pll_rst=0, sys_rst=1.
//    - lock_s=0: go to WAIT_LOCK, cnt=0. The timeout restarts.
//    - cnt==STABLE_CYCLES-1 with lock_s=1: go to RUN.
//  - RUN: pll_rst=0, sys_rst=0, pll_ready=1.
//    - lock_s=0 or relock_req=1: go to RESET_PLL. sys_rst=1 and pll_ready=0 on the
//      next edge, together with pll_rst=1.
//  - relock_req in WAIT_LOCK or STABLE: go to RESET_PLL, cnt=0. It takes priority over lock_s
//    and timeout. relock_req in RESET_PLL restarts the RST_CYCLES count (cnt=0).
//  - Simultaneous lock loss and relock_req: a single transition to RESET_PLL, counted once.
//  - Counter never wraps. Every transition clears it.
//  - Best case from rst release to sys_rst=0:
//    RST_CYCLES + 2 (sync) + 1 + STABLE_CYCLES + 1 cycles.
//  - rst asserted mid-operation: next edge returns to reset values, whatever the state.
// CONFIGURATION
//  PLL_SUPERVISOR_STATS_EN defined:
//    - Adds output relock_cnt [7:0]. Reset 0.
//    - +1 on every entry to RESET_PLL other than the one after rst: timeout, lock loss
//      or relock_req.
//    - Saturates at 8'hFF.
//    - Adds output timeout_seen, a sticky flag set by any WAIT_LOCK timeout, cleared only by rst.
//  Not defined: these ports and their registers do not exist. All other behaviour is identical.
// TESTING
//  - Params 4/20/8. rst 3 cycles, pll_lock tied 1.
//    -> pll_rst high exactly 4 cycles; sys_rst falls exactly 4+2+1+8+1 cycles after rst release.
//  - pll_lock held 0.
//    -> pll_rst re-pulses for 4 cycles every 24 cycles. With STATS_EN: relock_cnt increments
//       each time and timeout_seen=1.
//  - In STABLE, drop pll_lock for 1 cycle at count 5.
//    -> returns to WAIT_LOCK. sys_rst stays 1. The full 8 stable cycles are required again.
//  - In RUN, drop pll_lock.
//    -> sys_rst=1, pll_ready=0, pll_rst=1 on the 3rd edge after the drop.
//  - In RUN, relock_req pulse on the same cycle lock_s falls.
//    -> one RESET_PLL entry; relock_cnt +1 only.
//  - Force 300 timeouts with STATS_EN.
//    -> relock_cnt holds 8'hFF. Assert rst mid-WAIT_LOCK -> all outputs return to reset values.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Sequences a Gowin PLLVR running from the 27 MHz reference clock. The block
// pulses the PLL RESET pin, waits for LOCK, and requires LOCK to stay stable
// before it releases the downstream system reset. A lock loss, a lock timeout
// or a software relock request resets the PLL and starts the sequence again.
//
// Optional feature (macro PLL_SUPERVISOR_STATS_EN):
//   relock_cnt   out 8  saturating count of RESET_PLL entries caused by a
//                       timeout, a lock loss or relock_req (the entry that
//                       follows rst is not counted)
//   timeout_seen out 1  sticky; set by any WAIT_LOCK timeout, cleared by rst
// With the macro undefined these ports and their registers do not exist.
//
// Ports:
//   clk        in  1  reference clock (PLL clkin)
//   rst        in  1  synchronous active-high reset
//   pll_lock   in  1  PLLVR LOCK, asynchronous to clk
//   relock_req in  1  single-cycle pulse that forces a PLL reset and relock
//   pll_rst    out 1  to PLLVR RESET; high holds the PLL in reset
//   sys_rst    out 1  downstream reset; low only while running
//   pll_ready  out 1  high only in RUN
//   state_o    out 2  current state (0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN)
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 256,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       pll_ready,
  output logic [1:0] state_o
`ifdef PLL_SUPERVISOR_STATS_EN
  ,
  output logic [7:0] relock_cnt,
  output logic       timeout_seen
`endif
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             lock_meta;
  logic             lock_s;
  logic             pll_rst_d;

  assign state_o = state;

  // Two-flop LOCK synchronizer. LOCK means nothing while the PLL is held in
  // reset and may glitch right after RESET falls, so the chain is kept clear
  // for the whole reset pulse plus one cycle. A fresh lock therefore always
  // needs the full two synchronizer cycles after that mask lifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else if (pll_rst || pll_rst_d) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Next-state and counter logic. relock_req outranks every other condition,
  // and every transition clears the counter so it can never wrap.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      RESET_PLL: begin
        if (relock_req) begin
          next_cnt = '0;
        end else if (cnt == RST_LAST) begin
          next_state = WAIT_LOCK;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (relock_req) begin
          next_state = RESET_PLL;
          next_cnt   = '0;
        end else if (lock_s) begin
          next_state = STABLE;
          next_cnt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          next_state = RESET_PLL;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      STABLE: begin
        if (relock_req) begin
          next_state = RESET_PLL;
          next_cnt   = '0;
        end else if (!lock_s) begin
          next_state = WAIT_LOCK;
          next_cnt   = '0;
        end else if (cnt == STABLE_LAST) begin
          next_state = RUN;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (relock_req || !lock_s) begin
          next_state = RESET_PLL;
          next_cnt   = '0;
        end
      end
      default: begin
        next_state = RESET_PLL;
        next_cnt   = '0;
      end
    endcase
  end

  // State register and registered outputs. Outputs are decoded from the next
  // state so they change on the same edge as state_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      pll_rst_d <= 1'b1;
      sys_rst   <= 1'b1;
      pll_ready <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      pll_rst   <= (next_state == RESET_PLL);
      pll_rst_d <= pll_rst;
      sys_rst   <= (next_state != RUN);
      pll_ready <= (next_state == RUN);
    end
  end

`ifdef PLL_SUPERVISOR_STATS_EN
  // Relock statistics. Only transitions into RESET_PLL from another state
  // count, so a simultaneous lock loss and relock_req is a single event.
  always_ff @(posedge clk) begin
    if (rst) begin
      relock_cnt   <= 8'h00;
      timeout_seen <= 1'b0;
    end else begin
      if ((state != RESET_PLL) && (next_state == RESET_PLL) && (relock_cnt != 8'hFF)) begin
        relock_cnt <= relock_cnt + 8'h01;
      end
      if ((state == WAIT_LOCK) && !relock_req && !lock_s && (cnt == TIMEOUT_LAST)) begin
        timeout_seen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//
// Directed bench for pll_lock_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8. Inputs change on the falling edge; outputs are sampled on
// the falling edge after each rising edge. Statistics checks are compiled in
// only when PLL_SUPERVISOR_STATS_EN is defined.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       pll_ready;
  logic [1:0] state_o;
`ifdef PLL_SUPERVISOR_STATS_EN
  logic [7:0] relock_cnt;
  logic       timeout_seen;
`endif

  int total;
  int bad;

  pll_lock_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_lock    (pll_lock),
    .relock_req  (relock_req),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .pll_ready   (pll_ready),
    .state_o     (state_o)
`ifdef PLL_SUPERVISOR_STATS_EN
    ,
    .relock_cnt  (relock_cnt),
    .timeout_seen(timeout_seen)
`endif
  );

  // 10 time-unit reference clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic lock, input logic req);
    rst        = r;
    pll_lock   = lock;
    relock_req = req;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic e_pll_rst, input logic e_sys_rst,
                          input logic e_ready, input logic [1:0] e_state);
    checkOutput({tag, ".pll_rst"}, {7'd0, pll_rst}, {7'd0, e_pll_rst});
    checkOutput({tag, ".sys_rst"}, {7'd0, sys_rst}, {7'd0, e_sys_rst});
    checkOutput({tag, ".pll_ready"}, {7'd0, pll_ready}, {7'd0, e_ready});
    checkOutput({tag, ".state"}, {6'd0, state_o}, {6'd0, e_state});
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset for 3 cycles with LOCK tied high
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(3);
    checkAll("reset", 1'b1, 1'b1, 1'b0, 2'd0);
`ifdef PLL_SUPERVISOR_STATS_EN
    checkOutput("reset.relock_cnt", relock_cnt, 8'h00);
    checkOutput("reset.timeout_seen", {7'd0, timeout_seen}, 8'h00);
`endif

    // Power-up: PLL reset 4 cycles, release 16 cycles after rst release
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycles(3);
    checkAll("boot_e3", 1'b1, 1'b1, 1'b0, 2'd0);
    stepCycles(1);
    checkAll("boot_e4", 1'b0, 1'b1, 1'b0, 2'd1);
    stepCycles(3);
    checkAll("boot_e7", 1'b0, 1'b1, 1'b0, 2'd1);
    stepCycles(1);
    checkAll("boot_e8", 1'b0, 1'b1, 1'b0, 2'd2);
    stepCycles(7);
    checkAll("boot_e15", 1'b0, 1'b1, 1'b0, 2'd2);
    stepCycles(1);
    checkAll("boot_e16", 1'b0, 1'b0, 1'b1, 2'd3);

    // Lock loss in RUN: reset reaches the PLL on the 3rd edge
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(2);
    checkAll("drop_e2", 1'b0, 1'b0, 1'b1, 2'd3);
    stepCycles(1);
    checkAll("drop_e3", 1'b1, 1'b1, 1'b0, 2'd0);
`ifdef PLL_SUPERVISOR_STATS_EN
    checkOutput("drop.relock_cnt", relock_cnt, 8'h01);
`endif

    // LOCK stays low: 4-cycle pulse every 24 cycles
    stepCycles(3);
    checkAll("to_r6", 1'b1, 1'b1, 1'b0, 2'd0);
    stepCycles(1);
    checkAll("to_r7", 1'b0, 1'b1, 1'b0, 2'd1);
    stepCycles(19);
    checkAll("to_r26", 1'b0, 1'b1, 1'b0, 2'd1);
    stepCycles(1);
    checkAll("to_r27", 1'b1, 1'b1, 1'b0, 2'd0);
`ifdef PLL_SUPERVISOR_STATS_EN
    checkOutput("to.relock_cnt", relock_cnt, 8'h02);
    checkOutput("to.timeout_seen", {7'd0, timeout_seen}, 8'h01);
`endif

    // Lock returns; a 1-cycle dropout at STABLE count 5 restarts the wait
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycles(8);
    checkAll("st_e8", 1'b0, 1'b1, 1'b0, 2'd2);
    stepCycles(5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycles(2);
    checkAll("st_e16", 1'b0, 1'b1, 1'b0, 2'd1);
    stepCycles(1);
    checkAll("st_e17", 1'b0, 1'b1, 1'b0, 2'd2);
    stepCycles(7);
    checkAll("st_e24", 1'b0, 1'b1, 1'b0, 2'd2);
    stepCycles(1);
    checkAll("st_e25", 1'b0, 1'b0, 1'b1, 2'd3);

    // relock_req on the same cycle lock_s falls: one RESET_PLL entry
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(2);
    checkAll("both_f2", 1'b0, 1'b0, 1'b1, 2'd3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepCycles(1);
    checkAll("both_f3", 1'b1, 1'b1, 1'b0, 2'd0);
`ifdef PLL_SUPERVISOR_STATS_EN
    checkOutput("both_f3.relock_cnt", relock_cnt, 8'h03);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(1);
    checkAll("both_f4", 1'b1, 1'b1, 1'b0, 2'd0);
`ifdef PLL_SUPERVISOR_STATS_EN
    checkOutput("both_f4.relock_cnt", relock_cnt, 8'h03);
`endif

    // 300 consecutive timeouts; the PLL re-enters reset every 24 cycles
    stepCycles(23);
    checkAll("period", 1'b1, 1'b1, 1'b0, 2'd0);
    repeat (299) begin
      stepCycles(24);
      checkOutput("period.state", {6'd0, state_o}, 8'h00);
    end
`ifdef PLL_SUPERVISOR_STATS_EN
    checkOutput("sat.relock_cnt", relock_cnt, 8'hFF);
    checkOutput("sat.timeout_seen", {7'd0, timeout_seen}, 8'h01);
`endif

    // rst in the middle of WAIT_LOCK returns everything to reset values
    stepCycles(5);
    checkAll("mid_wait", 1'b0, 1'b1, 1'b0, 2'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycles(1);
    checkAll("mid_rst", 1'b1, 1'b1, 1'b0, 2'd0);
`ifdef PLL_SUPERVISOR_STATS_EN
    checkOutput("mid_rst.relock_cnt", relock_cnt, 8'h00);
    checkOutput("mid_rst.timeout_seen", {7'd0, timeout_seen}, 8'h00);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
